product_display: RTL and testbench

PRODUCT_DISPLAY -- requirements
Module: product_display

---
 rtl/product_display_if.sv | 29 ++
 rtl/product_display.sv | 182 ++++++++++++++++++
 tb/tb_product_display.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/product_display_if.sv
// ============================================================================
// Module      : product_display_if
// Description : Load/product inputs and status/7-segment outputs of product_display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface product_display_if;
  logic       Load;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       busy;
  logic       neg;
  logic       ovf;
  logic [7:0] hex_seg;
  logic [3:0] hex_grid;

  modport slave (
    input  Load, Aval, Bval,
    output busy, neg, ovf, hex_seg, hex_grid
  );

  modport master (
    output Load, Aval, Bval,
    input  busy, neg, ovf, hex_seg, hex_grid
  );
endinterface

`default_nettype wire

// File: rtl/product_display.sv
// ============================================================================
// Module      : product_display
// Description : Shows a 16-bit signed product on a 4-digit multiplexed 7-seg
//               display; decimal via double-dabble when PRODUCT_DISPLAY_BCD_EN
//               is defined, raw hex nibbles otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_display #(
  parameter int SCAN_DIV = 16
) (
  input wire              Clk,
  input wire              Reset,
  product_display_if.slave bus
);

  logic [15:0]         p_w;
  logic [15:0]         digits_q;
  logic                neg_q;
  logic [SCAN_DIV-1:0] scan_q;
  logic [1:0]          sel_w;
  logic [3:0]          digit_w;
  logic [7:0]          seg_w;
  logic [3:0]          grid_w;
  logic [7:0]          hex_seg_q;
  logic [3:0]          hex_grid_q;

  assign p_w = {bus.Aval, bus.Bval};

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction

`ifdef PRODUCT_DISPLAY_BCD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] mag_q, mag_d;
  logic [19:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic [15:0] digits_d;
  logic        neg_d;
  logic        ovf_q, ovf_d;
  logic [15:0] adj_w;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      digits_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      digits_q <= digits_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  // Only the low four digits need the add-3 correction; the fifth never shifts out.
  always_comb begin
    adj_w = bcd_q[15:0];
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj_w[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    digits_d = digits_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.Load) begin
          sign_d  = p_w[15];
          mag_d   = p_w[15] ? (~p_w + 16'd1) : p_w;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {bcd_q[18:16], adj_w, mag_q[15]};
        mag_d = {mag_q[14:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = DONE;
      end
      DONE: begin
        digits_d = bcd_q[15:0];
        ovf_d    = |bcd_q[19:16];
        neg_d    = sign_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.ovf  = ovf_q;
`else
  always_ff @(posedge Clk) begin
    if (Reset) begin
      digits_q <= '0;
      neg_q    <= 1'b0;
    end else if (bus.Load) begin
      digits_q <= p_w;
      neg_q    <= p_w[15];
    end
  end

  assign bus.busy = 1'b0;
  assign bus.ovf  = 1'b0;
`endif

  assign bus.neg = neg_q;

  always_comb begin
    sel_w = scan_q[SCAN_DIV-1 -: 2];
    case (sel_w)
      2'd0:    digit_w = digits_q[3:0];
      2'd1:    digit_w = digits_q[7:4];
      2'd2:    digit_w = digits_q[11:8];
      default: digit_w = digits_q[15:12];
    endcase
    seg_w  = seg7(digit_w);
`ifdef PRODUCT_DISPLAY_BCD_EN
    if (sel_w == 2'd3 && neg_q) seg_w[7] = 1'b0;
`endif
    grid_w = ~(4'b0001 << sel_w);
  end

  // Outputs registered, hence one cycle behind the digit select.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      scan_q     <= '0;
      hex_seg_q  <= 8'hC0;
      hex_grid_q <= 4'b1110;
    end else begin
      scan_q     <= scan_q + SCAN_DIV'(1);
      hex_seg_q  <= seg_w;
      hex_grid_q <= grid_w;
    end
  end

  assign bus.hex_seg  = hex_seg_q;
  assign bus.hex_grid = hex_grid_q;

endmodule

`default_nettype wire

// File: tb/tb_product_display.sv
// ============================================================================
// Module      : tb_product_display
// Description : Self-checking bench for product_display (hex or BCD build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  product_display_if bus ();

  product_display #(.SCAN_DIV(2)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] p;
    logic [15:0] d;
    logic        neg;
    logic        ovf;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] seg2hex(input logic [6:0] s);
    case (s)
      7'h40: seg2hex = 5'h10; 7'h79: seg2hex = 5'h11; 7'h24: seg2hex = 5'h12;
      7'h30: seg2hex = 5'h13; 7'h19: seg2hex = 5'h14; 7'h12: seg2hex = 5'h15;
      7'h02: seg2hex = 5'h16; 7'h78: seg2hex = 5'h17; 7'h00: seg2hex = 5'h18;
      7'h10: seg2hex = 5'h19; 7'h08: seg2hex = 5'h1A; 7'h03: seg2hex = 5'h1B;
      7'h46: seg2hex = 5'h1C; 7'h21: seg2hex = 5'h1D; 7'h06: seg2hex = 5'h1E;
      7'h0E: seg2hex = 5'h1F;
      default: seg2hex = 5'h00;
    endcase
  endfunction

  // Watch four consecutive scan slots and rebuild the shown digits and dp pattern.
  task automatic read_display(output logic [15:0] d, output logic [3:0] dpm,
                              output logic [3:0] seen);
    logic [4:0] dec;
    int idx;
    d = '0; dpm = '0; seen = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      case (bus.hex_grid)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      dec = seg2hex(bus.hex_seg[6:0]);
      if (idx >= 0) begin
        seen[idx]       = dec[4];
        d[idx*4 +: 4]   = dec[3:0];
        dpm[idx]        = ~bus.hex_seg[7];
      end
    end
  endtask

  task automatic check_display(input string tag, input logic [15:0] exp_d,
                               input logic exp_neg, input logic exp_ovf);
    logic [15:0] d;
    logic [3:0]  dpm, seen;
    logic [3:0]  exp_dp;
`ifdef PRODUCT_DISPLAY_BCD_EN
    exp_dp = {exp_neg, 3'b000};
`else
    exp_dp = 4'b0000;
`endif
    read_display(d, dpm, seen);
    chk({tag, "_seen"},   {28'd0, seen}, 32'hF);
    chk({tag, "_digits"}, {16'd0, d},    {16'd0, exp_d});
    chk({tag, "_dp"},     {28'd0, dpm},  {28'd0, exp_dp});
    chk({tag, "_neg"},    {31'd0, bus.neg}, {31'd0, exp_neg});
    chk({tag, "_ovf"},    {31'd0, bus.ovf}, {31'd0, exp_ovf});
  endtask

  task automatic apply(input string tag, input logic [15:0] p, input logic [15:0] exp_d,
                       input logic exp_neg, input logic exp_ovf);
    int cyc;
    @(negedge clk);
    bus.Load = 1'b1; bus.Aval = p[15:8]; bus.Bval = p[7:0];
    @(negedge clk);
    bus.Load = 1'b0;
`ifdef PRODUCT_DISPLAY_BCD_EN
    cyc = 0;
    while (bus.busy && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, cyc, 17);
`else
    cyc = 0;
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
`endif
    check_display(tag, exp_d, exp_neg, exp_ovf);
  endtask

  initial begin
`ifdef PRODUCT_DISPLAY_BCD_EN
    vecs[0] = '{16'hFFEB, 16'h0021, 1'b1, 1'b0};
    vecs[1] = '{16'h4000, 16'h6384, 1'b0, 1'b1};
    vecs[2] = '{16'h0063, 16'h0099, 1'b0, 1'b0};
    vecs[3] = '{16'h8000, 16'h2768, 1'b1, 1'b1};
    vecs[4] = '{16'h2710, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{16'h270F, 16'h9999, 1'b0, 1'b0};
    vecs[6] = '{16'hD8F1, 16'h9999, 1'b1, 1'b0};
    vecs[7] = '{16'h1234, 16'h4660, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
`else
    vecs[0] = '{16'hFFEB, 16'hFFEB, 1'b1, 1'b0};
    vecs[1] = '{16'h0123, 16'h0123, 1'b0, 1'b0};
    vecs[2] = '{16'h4567, 16'h4567, 1'b0, 1'b0};
    vecs[3] = '{16'h89AB, 16'h89AB, 1'b1, 1'b0};
    vecs[4] = '{16'hCDEF, 16'hCDEF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b1, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b0};
    vecs[7] = '{16'h4000, 16'h4000, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'h0000, 1'b0, 1'b0};
`endif

    bus.Load = 1'b0; bus.Aval = '0; bus.Bval = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grid", {28'd0, bus.hex_grid}, 32'hE);
    chk("rst_seg",  {24'd0, bus.hex_seg},  32'hC0);
    chk("rst_busy", {31'd0, bus.busy},     32'd0);
    rst = 1'b0;
    begin
      logic [3:0] exp_grid [4];
      exp_grid[0] = 4'b1110; exp_grid[1] = 4'b1101;
      exp_grid[2] = 4'b1011; exp_grid[3] = 4'b0111;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk($sformatf("rst_scan%0d_grid", i), {28'd0, bus.hex_grid}, {28'd0, exp_grid[i]});
        chk($sformatf("rst_scan%0d_seg", i),  {24'd0, bus.hex_seg},  32'hC0);
      end
    end
    chk("rst_neg", {31'd0, bus.neg}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      apply($sformatf("vec%0d", i), vecs[i].p, vecs[i].d, vecs[i].neg, vecs[i].ovf);
    end

`ifdef PRODUCT_DISPLAY_BCD_EN
    // A Load arriving mid-conversion must not disturb the conversion in flight.
    begin
      int cyc;
      @(negedge clk);
      bus.Load = 1'b1; bus.Aval = 8'h00; bus.Bval = 8'h63;
      @(negedge clk);
      bus.Load = 1'b0;
      cyc = 0;
      while (bus.busy && cyc < 40) begin
        cyc++;
        if (cyc == 5) begin
          bus.Load = 1'b1; bus.Aval = 8'h12; bus.Bval = 8'h34;
        end else begin
          bus.Load = 1'b0;
        end
        @(negedge clk);
      end
      bus.Load = 1'b0;
      chk("lockout_busy_cycles", cyc, 17);
      check_display("lockout", 16'h0099, 1'b0, 1'b0);
    end

    // Reset partway through CONV discards the partial result.
    begin
      int cyc;
      @(negedge clk);
      bus.Load = 1'b1; bus.Aval = 8'h27; bus.Bval = 8'h10;
      @(negedge clk);
      bus.Load = 1'b0;
      cyc = 0;
      while (bus.busy && cyc < 8) begin
        cyc++;
        if (cyc < 8) @(negedge clk);
      end
      chk("midrst_reached_step8", cyc, 8);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      chk("midrst_busy_after", {31'd0, bus.busy}, 32'd0);
      check_display("midrst", 16'h0000, 1'b0, 1'b0);
      apply("midrst_reload", 16'h2710, 16'h0000, 1'b0, 1'b1);
    end
`endif

    // Reset wins over a simultaneous Load.
    apply("pre_prio", 16'hFFEB, vecs[0].d, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1; bus.Load = 1'b1; bus.Aval = 8'h12; bus.Bval = 8'h34;
    @(negedge clk);
    rst = 1'b0; bus.Load = 1'b0;
    chk("prio_busy", {31'd0, bus.busy}, 32'd0);
    check_display("prio", 16'h0000, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
